collision_arbiter: RTL and testbench
====================================

# collision_arbiter

Frame-level scheduler for the billiard collision datapath. It samples per-pixel draw-request overlaps between the white ball, red ball, border and six holes during a frame, then snapshots them at start of frame. It dispatches the snapshot one event at a time to the single shared velocity resolver (border/ball/hole collision logic), using a request/done handshake. It also keeps the sunk-ball status that the game state logic reads.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, max cycles to wait for resolveDone before abandoning an event (1..1023)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- newShot  in  1  one-cycle pulse; clears sunk flags
- whiteBallDR, redBallDR, borderDR  in  1 each  pixel draw requests
- holeDR  in  6  hole draw requests, bit i = hole i+1
- resolveReq  out  1  event valid to resolver
- resolveBall  out  1  0 = white, 1 = red
- resolveType  out  2  0 = border, 1 = ball-ball, 2 = hole
- resolveDone  in  1  one-cycle pulse: resolver consumed the event
- frameResolved  out  1  one-cycle pulse: all events of the snapshot handled
- whiteSunk, redSunk  out  1 each  sticky sunk flags
- overrunErr, timeoutErr  out  1 each  sticky error flags

## Operation
- Event vector, 5 bits, combinational from DR inputs each cycle:
  - bit0 white-hole (whiteBallDR & |holeDR)
  - bit1 red-hole
  - bit2 white-red
  - bit3 white-border
  - bit4 red-border
- collect[4:0] ORs in the event vector every cycle.
- On startOfFrame: pending <= pending | collect; collect <= the current-cycle event vector only.
- FSM states: IDLE, DISPATCH, WAIT, DONE.
  - IDLE: on startOfFrame -> DISPATCH.
  - DISPATCH: if pending == 0 -> DONE. Otherwise take the lowest set bit (fixed priority bit0 > bit4), register resolveBall/resolveType/index, clear the timeout counter -> WAIT.
  - WAIT: resolveReq = 1. On resolveDone, clear that pending bit and go to DISPATCH. If the index is bit0, set whiteSunk; if bit1, set redSunk.
  - WAIT timeout: when the counter reaches TIMEOUT_CYCLES-1 without resolveDone, clear the bit, set timeoutErr, no sunk update, go to DISPATCH.
  - DONE: frameResolved = 1 -> IDLE.
- Event field encoding: white-red is issued with resolveBall=0, resolveType=1. Border events use type 0; hole events use type 2.
- startOfFrame outside IDLE: snapshot is still merged (pending |= collect), overrunErr set, FSM continues without restart.
- newShot clears whiteSunk/redSunk only; simultaneous with a sunk set, the set wins.
- reset: state IDLE, collect/pending/counter 0, all outputs 0, resolveBall 0, resolveType 0.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Latency from startOfFrame at cycle T:
  - DISPATCH at T+1.
  - resolveReq high at T+2, or frameResolved high at T+2 if the snapshot is empty.
  - IDLE at T+3 in the empty case.
- resolveDone is accepted in the same cycle resolveReq is high, including the first cycle of WAIT. Next event's req at done+2.
- resolveReq stays high and its fields stay stable until done or timeout. resolveDone outside WAIT is ignored.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

## Configuration
- HOLE_COLLISION_EN defined: hole events (bits 0, 1) captured and dispatched as above; sunk flags operate.
- HOLE_COLLISION_EN undefined:
  - holeDR is ignored and event bits 0/1 are constant 0.
  - whiteSunk/redSunk are tied 0; resolveType never equals 2.

## Test plan
- Reset, then startOfFrame with no DR activity -> no resolveReq; frameResolved pulses at T+2; all flags 0.
- During a frame, whiteBallDR & borderDR for 3 cycles, then startOfFrame -> one req (ball 0, type 0) at T+2; done at T+4 -> frameResolved at T+6.
- whiteBallDR & redBallDR & borderDR & holeDR=6'b000100 together, then SOF:
  - Events issued in order: white-hole, red-hole, white-red, white-border, red-border.
  - whiteSunk and redSunk set.
- With TIMEOUT_CYCLES=4, one pending event and no done -> req high for exactly 4 cycles, timeoutErr=1, frameResolved 2 cycles later.
- Second startOfFrame while in WAIT -> overrunErr=1; new events merged and dispatched in the same pass.
- Reset asserted mid-WAIT -> next cycle resolveReq=0, IDLE; the following SOF with no activity gives empty-frame behaviour.

Source files
------------

// File: rtl/collision_arbiter.sv
// rtl/collision_arbiter.sv - frame-level scheduler of collision events for the shared velocity resolver
// Define HOLE_COLLISION_EN to capture/dispatch hole events and run the sunk-ball flags.
module collision_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       newShot,
  input  logic       whiteBallDR,
  input  logic       redBallDR,
  input  logic       borderDR,
  input  logic [5:0] holeDR,
  output logic       resolveReq,
  output logic       resolveBall,
  output logic [1:0] resolveType,
  input  logic       resolveDone,
  output logic       frameResolved,
  output logic       whiteSunk,
  output logic       redSunk,
  output logic       overrunErr,
  output logic       timeoutErr
);

`ifdef HOLE_COLLISION_EN
  localparam bit HOLE_EN = 1'b1;
`else
  localparam bit HOLE_EN = 1'b0;
`endif

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT, DONE} state_t;

  state_t          state;
  logic [4:0]      ev;
  logic [4:0]      collect;
  logic [4:0]      pending;
  logic [4:0]      clr;
  logic [2:0]      idx;
  logic [2:0]      pick_idx;
  logic            pick_ball;
  logic [1:0]      pick_type;
  logic [CW-1:0]   cnt;
  logic            hole_hit;
  logic            ev_done;
  logic            ev_timeout;

  assign hole_hit = HOLE_EN & (|holeDR);
  assign ev = {redBallDR & borderDR, whiteBallDR & borderDR, whiteBallDR & redBallDR,
               redBallDR & hole_hit, whiteBallDR & hole_hit};

  assign ev_done    = (state == WAIT) && resolveDone;
  assign ev_timeout = (state == WAIT) && !resolveDone && (cnt == CNT_LAST);

  // Fixed priority: the lowest pending bit is dispatched first.
  always_comb begin
    pick_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) pick_idx = 3'(i);
    end
  end

  always_comb begin
    pick_ball = 1'b0;
    pick_type = 2'd0;
    case (pick_idx)
      3'd0:    begin pick_ball = 1'b0; pick_type = 2'd2; end
      3'd1:    begin pick_ball = 1'b1; pick_type = 2'd2; end
      3'd2:    begin pick_ball = 1'b0; pick_type = 2'd1; end
      3'd3:    begin pick_ball = 1'b0; pick_type = 2'd0; end
      3'd4:    begin pick_ball = 1'b1; pick_type = 2'd0; end
      default: begin pick_ball = 1'b0; pick_type = 2'd0; end
    endcase
  end

  always_comb begin
    clr = 5'd0;
    if (ev_done || ev_timeout) clr[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      collect       <= 5'd0;
      pending       <= 5'd0;
      idx           <= 3'd0;
      cnt           <= '0;
      resolveReq    <= 1'b0;
      resolveBall   <= 1'b0;
      resolveType   <= 2'd0;
      frameResolved <= 1'b0;
      whiteSunk     <= 1'b0;
      redSunk       <= 1'b0;
      overrunErr    <= 1'b0;
      timeoutErr    <= 1'b0;
    end else begin
      collect <= startOfFrame ? ev : (collect | ev);
      pending <= (pending & ~clr) | (startOfFrame ? collect : 5'd0);

      if (startOfFrame && state != IDLE) overrunErr <= 1'b1;

      // A sunk set in the same cycle as newShot takes precedence.
      if (HOLE_EN && ev_done && idx == 3'd0) whiteSunk <= 1'b1;
      else if (newShot)                      whiteSunk <= 1'b0;
      if (HOLE_EN && ev_done && idx == 3'd1) redSunk <= 1'b1;
      else if (newShot)                      redSunk <= 1'b0;

      frameResolved <= 1'b0;

      case (state)
        IDLE: begin
          if (startOfFrame) state <= DISPATCH;
        end
        DISPATCH: begin
          if (pending == 5'd0) begin
            frameResolved <= 1'b1;
            state         <= DONE;
          end else begin
            idx         <= pick_idx;
            resolveBall <= pick_ball;
            resolveType <= pick_type;
            resolveReq  <= 1'b1;
            cnt         <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (resolveDone) begin
            resolveReq <= 1'b0;
            state      <= DISPATCH;
          end else if (cnt == CNT_LAST) begin
            resolveReq <= 1'b0;
            timeoutErr <= 1'b1;
            state      <= DISPATCH;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_arbiter.sv
// tb/tb_collision_arbiter.sv - randomized self-checking bench for collision_arbiter
// Reference model tracks collected/pending event sets and flags from the event rules.
module tb_collision_arbiter;

  localparam int TO = 4;

`ifdef HOLE_COLLISION_EN
  localparam bit HOLES = 1'b1;
`else
  localparam bit HOLES = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame, newShot, whiteBallDR, redBallDR, borderDR, resolveDone;
  logic [5:0] holeDR;
  logic       resolveReq, resolveBall, frameResolved, whiteSunk, redSunk, overrunErr, timeoutErr;
  logic [1:0] resolveType;

  int checks = 0;
  int failures = 0;

  logic [4:0] mcol, mpend;
  logic       mws, mrs, mterr, movr;
  bit         noise, ns_with_done;

  collision_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .newShot(newShot),
    .whiteBallDR(whiteBallDR), .redBallDR(redBallDR), .borderDR(borderDR), .holeDR(holeDR),
    .resolveReq(resolveReq), .resolveBall(resolveBall), .resolveType(resolveType),
    .resolveDone(resolveDone), .frameResolved(frameResolved), .whiteSunk(whiteSunk),
    .redSunk(redSunk), .overrunErr(overrunErr), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] events_of(input logic w, input logic r, input logic b,
                                           input logic [5:0] h);
    logic hh;
    hh = HOLES && (h != 6'd0);
    return {r && b, w && b, w && r, r && hh, w && hh};
  endfunction

  function automatic int lowest(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  // {ball, type} for each event kind
  function automatic logic [2:0] fields_of(input int k);
    case (k)
      0: return {1'b0, 2'd2};
      1: return {1'b1, 2'd2};
      2: return {1'b0, 2'd1};
      3: return {1'b0, 2'd0};
      default: return {1'b1, 2'd0};
    endcase
  endfunction

  task automatic model_reset();
    mcol = 5'd0; mpend = 5'd0; mws = 1'b0; mrs = 1'b0; mterr = 1'b0; movr = 1'b0;
  endtask

  task automatic step(input logic sof, input logic ns, input logic done, input logic w,
                      input logic r, input logic b, input logic [5:0] h);
    startOfFrame = sof; newShot = ns; resolveDone = done;
    whiteBallDR = w; redBallDR = r; borderDR = b; holeDR = h;
    if (ns) begin mws = 1'b0; mrs = 1'b0; end
    if (sof) begin
      mpend = mpend | mcol;
      mcol  = events_of(w, r, b, h);
    end else begin
      mcol = mcol | events_of(w, r, b, h);
    end
    @(posedge clk); #1;
    startOfFrame = 0; newShot = 0; resolveDone = 0;
    whiteBallDR = 0; redBallDR = 0; borderDR = 0; holeDR = 6'd0;
  endtask

  task automatic rstep(input logic sof, input logic done);
    logic w, r, b, ns;
    logic [5:0] h;
    w = 0; r = 0; b = 0; ns = 0; h = 6'd0;
    if (noise) begin
      w  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 2) == 0);
      ns = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) h = 6'(1 << $urandom_range(0, 5));
    end
    step(sof, ns, done, w, r, b, h);
  endtask

  // Entered one cycle after the startOfFrame step; resolves every pending event.
  task automatic serve(input int dmode, input bit ovr_sof);
    int k, d, lim, waited;
    bit first;
    logic [2:0] f;
    checks++;
    if ({resolveReq, frameResolved} !== 2'b00) begin
      failures++; $display("FAIL dispatch_quiet: req/fr=%b expected 00", {resolveReq, frameResolved});
    end
    rstep(0, 0);
    first = 1;
    while (mpend != 5'd0) begin
      k = lowest(mpend);
      f = fields_of(k);
      checks++;
      if ({resolveReq, resolveBall, resolveType} !== {1'b1, f}) begin
        failures++;
        $display("FAIL req_fields: got %b expected %b (event %0d)",
                 {resolveReq, resolveBall, resolveType}, {1'b1, f}, k);
      end
      d = (dmode < 0) ? $urandom_range(0, 2) : dmode;
      waited = 0;
      if (first && ovr_sof) begin
        rstep(1, 0);
        movr = 1'b1;
        waited = 1;
        checks++;
        if ({overrunErr, resolveReq} !== 2'b11) begin
          failures++; $display("FAIL overrun_flag: ovr/req=%b expected 11", {overrunErr, resolveReq});
        end
      end
      first = 0;
      lim = (d >= TO) ? TO - 1 : d;
      while (waited < lim) begin
        rstep(0, 0);
        waited++;
        checks++;
        if ({resolveReq, resolveBall, resolveType} !== {1'b1, f}) begin
          failures++;
          $display("FAIL req_hold: got %b expected %b", {resolveReq, resolveBall, resolveType}, {1'b1, f});
        end
      end
      mpend[k] = 1'b0;
      if (d >= TO) begin
        mterr = 1'b1;
        rstep(0, 0);
      end else begin
        if (ns_with_done) step(0, 1, 1, 0, 0, 0, 6'd0);
        else rstep(0, 1);
        if (k == 0) mws = 1'b1;
        if (k == 1) mrs = 1'b1;
      end
      checks++;
      if ({resolveReq, timeoutErr, whiteSunk, redSunk, overrunErr} !== {1'b0, mterr, mws, mrs, movr}) begin
        failures++;
        $display("FAIL after_event: req/to/ws/rs/ovr=%b expected %b",
                 {resolveReq, timeoutErr, whiteSunk, redSunk, overrunErr}, {1'b0, mterr, mws, mrs, movr});
      end
      rstep(0, 0);
    end
    checks++;
    if ({frameResolved, resolveReq} !== 2'b10) begin
      failures++; $display("FAIL frame_resolved: fr/req=%b expected 10", {frameResolved, resolveReq});
    end
    rstep(0, 0);
    checks++;
    if (frameResolved !== 1'b0) begin
      failures++; $display("FAIL frame_pulse_width: fr=%b expected 0", frameResolved);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({resolveReq, resolveBall, resolveType, frameResolved, whiteSunk, redSunk, overrunErr, timeoutErr} !== 9'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0",
               {resolveReq, resolveBall, resolveType, frameResolved, whiteSunk, redSunk, overrunErr, timeoutErr});
    end
    reset = 0;
    model_reset();
  endtask

  task automatic test_empty_frame();
    step(1, 0, 0, 0, 0, 0, 6'd0);
    serve(-1, 0);
    checks++;
    if ({whiteSunk, redSunk, overrunErr, timeoutErr} !== 4'd0) begin
      failures++; $display("FAIL empty_flags: got %b expected 0000", {whiteSunk, redSunk, overrunErr, timeoutErr});
    end
  endtask

  task automatic test_border();
    repeat (3) step(0, 0, 0, 1, 0, 1, 6'd0);
    step(1, 0, 0, 0, 0, 0, 6'd0);
    serve(2, 0);
  endtask

  task automatic test_all_events();
    step(0, 0, 0, 1, 1, 1, 6'b000100);
    step(1, 0, 0, 0, 0, 0, 6'd0);
    serve(1, 0);
    checks++;
    if ({whiteSunk, redSunk} !== {HOLES, HOLES}) begin
      failures++; $display("FAIL sunk_set: got %b expected %b", {whiteSunk, redSunk}, {HOLES, HOLES});
    end
  endtask

  task automatic test_newshot();
    step(0, 1, 0, 0, 0, 0, 6'd0);
    checks++;
    if ({whiteSunk, redSunk} !== 2'b00) begin
      failures++; $display("FAIL newshot_clear: got %b expected 00", {whiteSunk, redSunk});
    end
    step(0, 0, 0, 1, 0, 0, 6'b100000);
    step(1, 0, 0, 0, 0, 0, 6'd0);
    ns_with_done = 1;
    serve(0, 0);
    ns_with_done = 0;
    checks++;
    if ({whiteSunk, redSunk} !== {HOLES, 1'b0}) begin
      failures++; $display("FAIL set_beats_newshot: got %b expected %b", {whiteSunk, redSunk}, {HOLES, 1'b0});
    end
  endtask

  task automatic test_timeout();
    step(0, 0, 0, 1, 1, 0, 6'd0);
    step(1, 0, 0, 0, 0, 0, 6'd0);
    serve(TO + 5, 0);
  endtask

  task automatic test_overrun();
    step(0, 0, 0, 1, 0, 1, 6'd0);
    step(1, 0, 0, 0, 1, 1, 6'd0);
    serve(2, 1);
  endtask

  task automatic test_random();
    noise = 1;
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(1, 6)) rstep(0, 0);
      rstep(1, 0);
      serve(($urandom_range(0, 5) == 0) ? TO + 2 : -1, ($urandom_range(0, 4) == 0));
    end
    noise = 0;
  endtask

  task automatic test_reset_mid_wait();
    step(0, 0, 0, 1, 0, 1, 6'd0);
    step(1, 0, 0, 0, 0, 0, 6'd0);
    step(0, 0, 0, 0, 0, 0, 6'd0);
    checks++;
    if (resolveReq !== 1'b1) begin
      failures++; $display("FAIL mid_wait_req: got %b expected 1", resolveReq);
    end
    reset = 1;
    @(posedge clk); #1;
    checks++;
    if ({resolveReq, frameResolved, overrunErr, timeoutErr} !== 4'd0) begin
      failures++;
      $display("FAIL reset_in_wait: got %b expected 0000", {resolveReq, frameResolved, overrunErr, timeoutErr});
    end
    reset = 0;
    model_reset();
    step(1, 0, 0, 0, 0, 0, 6'd0);
    serve(-1, 0);
  endtask

  initial begin
    reset = 1; startOfFrame = 0; newShot = 0; resolveDone = 0;
    whiteBallDR = 0; redBallDR = 0; borderDR = 0; holeDR = 6'd0;
    noise = 0; ns_with_done = 0;
    model_reset();
    test_reset();
    test_empty_frame();
    test_border();
    test_all_events();
    test_newshot();
    test_timeout();
    test_overrun();
    test_random();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
